// File: rtl/btn_pkg.sv
// Shared timing defaults and channel state encoding for the multi-button debouncer.
package btn_pkg;

  localparam int unsigned DEF_TICK_CLKS     = 2500;
  localparam int unsigned DEF_STABLE_TICKS  = 100;
  localparam int unsigned DEF_REPEAT_DELAY  = 5000;
  localparam int unsigned DEF_REPEAT_PERIOD = 1000;

  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } btn_state_e;

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-flop synchroniser, tick-based stability filter,
// press/release strobes and optional hold-to-repeat strobe.
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_TICKS  = DEF_STABLE_TICKS,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic e_debug,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int unsigned CNT_W  = $clog2(STABLE_TICKS + 1);
  localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCNT_W = $clog2(RMAX + 1);

  logic [1:0]       sync_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             s, s_next;

  // s is the synchronised input (1 = pressed); s_next is what s becomes next clock
  assign s      = ~sync_q[1];
  assign s_next = ~sync_q[0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Next state: debug mode tracks s directly, otherwise s must differ for STABLE_TICKS ticks
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (e_debug) begin
      state_d = s_next ? ST_PRESSED : ST_RELEASED;
    end else if (s != (state_q == ST_PRESSED)) begin
      if (tick) begin
        if (cnt_q == CNT_W'(STABLE_TICKS - 1)) begin
          state_d = s ? ST_PRESSED : ST_RELEASED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Strobe generation on level transitions
  always_comb begin
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (state_d == ST_PRESSED && state_q == ST_RELEASED) press_d = 1'b1;
    if (state_d == ST_RELEASED && state_q == ST_PRESSED) rel_d = 1'b1;
  end

  assign level = (state_q == ST_PRESSED);
  assign press = press_q;
  assign rel   = rel_q;

  if (REPEAT_EN != 0) begin : g_repeat
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              rpt_q, rpt_d;

    // Repeat timer: first strobe at REPEAT_DELAY, then reload so later ones are REPEAT_PERIOD apart
    always_comb begin
      rcnt_d = rcnt_q;
      rpt_d  = 1'b0;
      if (e_debug || state_q == ST_RELEASED || press_q) begin
        rcnt_d = '0;
      end else if (tick) begin
        if (rcnt_q == RCNT_W'(REPEAT_DELAY - 1)) begin
          rcnt_d = RCNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
          rpt_d  = (state_d == ST_PRESSED);
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rcnt_q <= '0;
        rpt_q  <= 1'b0;
      end else begin
        rcnt_q <= rcnt_d;
        rpt_q  <= rpt_d;
      end
    end

    assign rpt = rpt_q;
  end else begin : g_no_repeat
    assign rpt = 1'b0;
  end

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel active-low button debouncer with a shared sample-tick prescaler.
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int unsigned N_BUTTONS     = 3,
  parameter int unsigned TICK_CLKS     = DEF_TICK_CLKS,
  parameter int unsigned STABLE_TICKS  = DEF_STABLE_TICKS,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 e_debug,
  input  logic [N_BUTTONS-1:0] btns_in,
  output logic [N_BUTTONS-1:0] btns_level,
  output logic [N_BUTTONS-1:0] btns_press,
  output logic [N_BUTTONS-1:0] btns_release,
  output logic [N_BUTTONS-1:0] btns_repeat
);

  localparam int unsigned PRE_W = $clog2(TICK_CLKS);

  logic [PRE_W-1:0] pre_q;
  logic             tick;

  assign tick = (pre_q == PRE_W'(TICK_CLKS - 1));

  // Free-running sample prescaler shared by all channels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < int'(N_BUTTONS); i++) begin : g_chan
    btn_debounce_chan #(
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .e_debug(e_debug),
      .btn_in (btns_in[i]),
      .level  (btns_level[i]),
      .press  (btns_press[i]),
      .rel    (btns_release[i]),
      .rpt    (btns_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench for btn_debounce_multi: vector table, directed corner cases, random vs model.
module tb_btn_debounce_multi;

  localparam int N  = 3;
  localparam int TK = 4;
  localparam int ST = 3;
  localparam int RD = 5;
  localparam int RP = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         e_debug;
  logic [N-1:0] btns_in;
  logic [N-1:0] btns_level, btns_press, btns_release, btns_repeat;

  always #5 clk = ~clk;

  btn_debounce_multi #(
    .N_BUTTONS    (N),
    .TICK_CLKS    (TK),
    .STABLE_TICKS (ST),
    .REPEAT_EN    (1),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .e_debug     (e_debug),
    .btns_in     (btns_in),
    .btns_level  (btns_level),
    .btns_press  (btns_press),
    .btns_release(btns_release),
    .btns_repeat (btns_repeat)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int np[N], nr[N], nq[N];

  // Reference model: ticks from a cycle phase, repeats from ticks held since press
  int           pc;
  logic [N-1:0] m1, m2, ml, mp, mr, mq;
  int           mc[N], mh[N];

  always @(posedge clk or posedge rst) begin : model
    bit tk, s, nl, rep;
    if (rst) begin
      pc = 0;
      m1 = '1; m2 = '1; ml = '0; mp = '0; mr = '0; mq = '0;
      for (int i = 0; i < N; i++) begin mc[i] = 0; mh[i] = 0; end
    end else begin
      tk = (pc == TK - 1);
      pc = (pc + 1) % TK;
      for (int i = 0; i < N; i++) begin
        s   = !m2[i];
        rep = 1'b0;
        if (e_debug) begin
          nl = !m1[i]; mc[i] = 0; mh[i] = 0;
        end else begin
          nl = ml[i];
          if (s == ml[i]) mc[i] = 0;
          else if (tk) begin
            mc[i]++;
            if (mc[i] == ST) begin nl = s; mc[i] = 0; end
          end
          if (!ml[i] || mp[i]) mh[i] = 0;
          else if (tk) begin
            mh[i]++;
            rep = nl && (mh[i] == RD || (mh[i] > RD && (mh[i] - RD) % RP == 0));
          end
        end
        mp[i] = nl && !ml[i];
        mr[i] = !nl && ml[i];
        mq[i] = rep;
        ml[i] = nl;
        m2[i] = m1[i];
        m1[i] = btns_in[i];
      end
    end
  end

  task automatic clr_counts();
    for (int i = 0; i < N; i++) begin np[i] = 0; nr[i] = 0; nq[i] = 0; end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock, compare against the model at the falling edge, count strobes
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    checks++;
    if ({btns_level, btns_press, btns_release, btns_repeat} !== {ml, mp, mr, mq}) begin
      errors++;
      $display("FAIL model cyc=%0d level=%b/%b press=%b/%b release=%b/%b repeat=%b/%b",
               cyc, btns_level, ml, btns_press, mp, btns_release, mr, btns_repeat, mq);
    end
    for (int i = 0; i < N; i++) begin
      np[i] += int'(btns_press[i]);
      nr[i] += int'(btns_release[i]);
      nq[i] += int'(btns_repeat[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; e_debug = 1'b0; btns_in = '1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic         dbg;
    logic [N-1:0] in;
    int           ncyc;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rls;
  } vec_t;

  vec_t tab[8];

  initial begin
    int lat, t_first, t_second, t_rise, hi, found;
    tab[0] = '{1'b0, 3'b111, 20, 3'b000, 3'b000, 3'b000};
    tab[1] = '{1'b0, 3'b110, 20, 3'b001, 3'b001, 3'b000};
    tab[2] = '{1'b0, 3'b100, 20, 3'b011, 3'b010, 3'b000};
    tab[3] = '{1'b0, 3'b011, 20, 3'b100, 3'b100, 3'b011};
    tab[4] = '{1'b0, 3'b111, 20, 3'b000, 3'b000, 3'b100};
    tab[5] = '{1'b1, 3'b010, 6,  3'b101, 3'b101, 3'b000};
    tab[6] = '{1'b1, 3'b111, 6,  3'b000, 3'b000, 3'b101};
    tab[7] = '{1'b0, 3'b000, 20, 3'b111, 3'b111, 3'b000};

    rst = 1'b1; e_debug = 1'b0; btns_in = '1;
    clr_counts();
    repeat (2) step();
    chk("reset_level", int'(btns_level), 0);
    chk("reset_press", int'(btns_press), 0);
    chk("reset_release", int'(btns_release), 0);
    chk("reset_repeat", int'(btns_repeat), 0);
    rst = 1'b0;

    // Vector table
    for (int k = 0; k < 8; k++) begin
      e_debug = tab[k].dbg;
      btns_in = tab[k].in;
      clr_counts();
      repeat (tab[k].ncyc) step();
      chk($sformatf("tab%0d_level", k), int'(btns_level), int'(tab[k].lvl));
      for (int b = 0; b < N; b++) begin
        chk($sformatf("tab%0d_press%0d", k, b), np[b], int'(tab[k].prs[b]));
        chk($sformatf("tab%0d_release%0d", k, b), nr[b], int'(tab[k].rls[b]));
      end
    end

    // Clean press latency
    do_reset();
    repeat (20) step();
    clr_counts();
    btns_in[0] = 1'b0;
    lat = 0;
    while (!btns_level[0] && lat < 40) begin step(); lat++; end
    chk("clean_latency_in_range", int'(lat >= 11 && lat <= 14), 1);
    repeat (5) step();
    chk("clean_press0", np[0], 1);
    chk("clean_press12", np[1] + np[2], 0);
    chk("clean_level12", int'(btns_level[2:1]), 0);

    // Bounce then settle
    do_reset();
    clr_counts();
    for (int t = 0; t < 40; t++) begin
      if (t % 3 == 0) btns_in[1] = ~btns_in[1];
      step();
    end
    btns_in[1] = 1'b0;
    repeat (20) step();
    chk("bounce_press1", np[1], 1);
    chk("bounce_release1", nr[1], 0);
    chk("bounce_level1", int'(btns_level[1]), 1);

    // Hold and auto-repeat
    do_reset();
    btns_in[2] = 1'b0;
    found = 0;
    for (int t = 0; t < 40 && found == 0; t++) begin
      step();
      if (btns_press[2]) found = 1;
    end
    chk("hold_press_seen", found, 1);
    t_first = -1; t_second = -1;
    for (int t = 1; t <= 60; t++) begin
      step();
      if (btns_repeat[2]) begin
        if (t_first < 0) t_first = t;
        else if (t_second < 0) t_second = t;
      end
    end
    chk("repeat_first", t_first, 20);
    chk("repeat_gap", t_second - t_first, 8);
    btns_in[2] = 1'b1;
    found = 0;
    for (int t = 0; t < 40 && found == 0; t++) begin
      step();
      if (btns_release[2]) found = 1;
    end
    chk("hold_release_seen", found, 1);
    clr_counts();
    repeat (30) step();
    chk("no_repeat_after_release", nq[2], 0);
    chk("single_release", nr[2], 0);

    // Simultaneous press, then single release
    do_reset();
    btns_in = 3'b000;
    found = 0;
    for (int t = 0; t < 40 && found == 0; t++) begin
      step();
      if (btns_press != 0) found = int'(btns_press);
    end
    chk("simul_press", found, 7);
    repeat (5) step();
    clr_counts();
    btns_in = 3'b010;
    repeat (20) step();
    chk("simul_release0", nr[0], 0);
    chk("simul_release1", nr[1], 1);
    chk("simul_release2", nr[2], 0);
    chk("simul_level", int'(btns_level), 5);

    // Reset during the stability window
    do_reset();
    btns_in[0] = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step();
      chk("midreset_outputs",
          int'({btns_level, btns_press, btns_release, btns_repeat}), 0);
    end
    rst = 1'b0;
    clr_counts();
    lat = 0;
    while (!btns_level[0] && lat < 40) begin step(); lat++; end
    chk("midreset_latency_in_range", int'(lat >= 11 && lat <= 14), 1);
    chk("midreset_press", np[0], 1);
    chk("midreset_release", nr[0], 0);

    // Debug bypass
    do_reset();
    e_debug = 1'b1;
    repeat (3) step();
    clr_counts();
    btns_in[0] = 1'b0;
    t_rise = -1; hi = 0;
    for (int t = 1; t <= 10; t++) begin
      step();
      if (btns_level[0]) begin
        hi++;
        if (t_rise < 0) t_rise = t;
      end
      if (t == 2) btns_in[0] = 1'b1;
    end
    chk("debug_rise", t_rise, 2);
    chk("debug_high_cycles", hi, 2);
    chk("debug_press", np[0], 1);
    chk("debug_release", nr[0], 1);
    chk("debug_repeat", nq[0] + nq[1] + nq[2], 0);
    clr_counts();
    e_debug = 1'b0;
    repeat (5) step();
    chk("debug_exit_strobes", np[0] + nr[0] + np[1] + nr[1] + np[2] + nr[2], 0);

    // Randomised traffic against the model
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 39) == 0) btns_in[b] = ~btns_in[b];
      if ($urandom_range(0, 299) == 0) e_debug = ~e_debug;
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
Parametrised successor to the single-shot button debouncer. It filters N independent active-low push-buttons, each with its own stability counter and state machine. Per channel it produces a clean pressed level, one-cycle press and release strobes, and an optional hold-to-auto-repeat strobe. It sits between the raw board pins and the game/menu controller. A shared tick prescaler keeps the per-channel counters narrow.

Parameters:
N_BUTTONS, 3, number of independent button channels
TICK_CLKS, 2500, clocks per sample tick (100 us at 25 MHz); minimum 2
STABLE_TICKS, 100, consecutive ticks the input must differ from the current level before the level flips (10 ms); minimum 1
REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = btns_repeat tied to 0 and repeat logic removed
REPEAT_DELAY, 5000, ticks from press to the first repeat strobe (500 ms)
REPEAT_PERIOD, 1000, ticks between subsequent repeat strobes (100 ms)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
e_debug  input  1  1 = bypass filtering (see Behaviour)
btns_in  input  N_BUTTONS  raw buttons, active-low (0 = pressed)
btns_level  output  N_BUTTONS  debounced state, active-high (1 = pressed)
btns_press  output  N_BUTTONS  1-cycle strobe on debounced press
btns_release  output  N_BUTTONS  1-cycle strobe on debounced release
btns_repeat  output  N_BUTTONS  1-cycle strobe per auto-repeat while held

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: all synchroniser flops = 1 (released). btns_level, btns_press, btns_release and btns_repeat = 0. Prescaler, stability and repeat counters = 0.
- Reset asserted mid-operation: everything returns to these values immediately. No strobe is emitted on reset entry or exit.
- Synchroniser: 2 flops per bit. s = second stage, inverted, so that 1 = pressed.
- Prescaler: counts 0..TICK_CLKS-1 and wraps. tick = 1 for exactly one clock when the count is TICK_CLKS-1. It free-runs and is shared by all channels.
- Per-channel stability counter cnt, width $clog2(STABLE_TICKS+1):
  - If s == level on any clock, cnt is cleared to 0. This takes priority over tick.
  - Otherwise, on tick: if cnt == STABLE_TICKS-1, level <= s and cnt <= 0; else cnt increments.
- Strobes are registered. btns_press asserts in the same cycle that level goes 0->1, and btns_release in the same cycle that level goes 1->0. Each lasts exactly 1 cycle.
- Latency from raw edge to level change: between 2 + (STABLE_TICKS-1)*TICK_CLKS + 1 and 2 + STABLE_TICKS*TICK_CLKS clocks.
- Auto-repeat (REPEAT_EN=1):
  - Per-channel rcnt, width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1). It is cleared while level = 0 and in the cycle of the press strobe.
  - While level = 1, rcnt increments on tick.
  - When rcnt reaches REPEAT_DELAY, the first repeat strobe fires and rcnt reloads to REPEAT_DELAY-REPEAT_PERIOD. Subsequent strobes therefore fire every REPEAT_PERIOD ticks.
  - A release clears rcnt; a pending repeat is never emitted after release.
  - Repeat never coincides with press; the first repeat comes REPEAT_DELAY ticks after press.
- Channels are fully independent. Simultaneous presses yield simultaneous strobes on every affected bit.
- e_debug = 1:
  - btns_level = s (synchronised, unfiltered).
  - press and release are strobes on edges of s.
  - btns_repeat = 0.
  - cnt and rcnt are held at 0.
  - Leaving debug mode resumes filtering from the current level without a spurious strobe.
- Glitch shorter than one tick window: at least one clock with s == level clears cnt, so no level change results.

Decomposition:
- Shared package btn_pkg holds the default timing constants (DEF_TICK_CLKS, DEF_STABLE_TICKS, DEF_REPEAT_DELAY, DEF_REPEAT_PERIOD) and the channel state encoding (ST_RELEASED, ST_PRESSED).
- One sub-module, btn_debounce_chan, contains the synchroniser, stability counter, level flop, strobes and repeat counter for a single bit.
- The top level holds the prescaler plus a generate loop of N_BUTTONS instances.

Test Plan (N_BUTTONS=3, TICK_CLKS=4, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_PERIOD=2):
- Clean press: btns_in[0] held 0 from cycle 20 -> btns_level[0] rises in cycles 31..34. btns_press[0] is high exactly that one cycle. Bits 1 and 2 stay 0.
- Bounce: btns_in[1] toggles every 3 cycles for 40 cycles, then settles at 0 -> exactly one btns_press[1], no release, and the level is stable afterwards.
- Hold and repeat: hold btns_in[2] low for 60 cycles after its press -> first btns_repeat[2] 20 cycles (5 ticks) after press, then every 8 cycles. Release -> one btns_release[2] and no further repeats.
- Simultaneous: btns_in = 3'b000 at one cycle -> all three press strobes in the same cycle. Then release bit 1 only -> only btns_release[1].
- Reset mid-count: assert rst during the bit-0 stability window, deassert, keep the button pressed -> all outputs 0 during reset. Press recognised at a full debounce latency measured from rst deassertion. No release strobe.
- Debug bypass: e_debug=1, pulse btns_in[0] low for 2 cycles -> btns_level[0] high for 2 cycles starting 2 cycles later, with one press and one release strobe and no repeat.
